// File: rtl/mem_datos_param.sv
// mem_datos_param: parametrised, byte-writable data memory for the processor datapath.
//
// A DEPTH-word array mapped at BASE_ADDR. It is accessed through active-low request
// strobes with WAIT_STATES programmable wait cycles. Each access completes with a
// one-cycle acknowledge, and an error flag marks out-of-range or misaligned addresses.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   Mem_rd        read request strobe, active-low (wins over Mem_wr)
//   Mem_wr        write request strobe, active-low
//   Dir_Mem       byte address
//   Dato_Mem_in   write data
//   Byte_en       write lane enables, lane i = bits [8i+7:8i]
//   Dato_Mem_out  read data, held until the next read completes
//   Mem_busy      high while a request waits (WAIT state)
//   Mem_ack       one-cycle completion pulse
//   Mem_err       qualified by Mem_ack: the access was out of range or misaligned
//
// Configuration macro: MEM_DATOS_INIT_EN
//   defined   : the array is built from reset flops; rst loads word0..2 with fixed
//               values and clears every other word.
//   undefined : rst leaves the array untouched, so the array can map to RAM.

module mem_datos_param #(
  parameter int unsigned             DATA_W       = 32,
  parameter int unsigned             ADDR_W       = 32,
  parameter int unsigned             DEPTH        = 16,
  parameter logic [ADDR_W-1:0]       BASE_ADDR    = 32'h10000000,
  parameter int unsigned             WAIT_STATES  = 1,
  parameter logic [DATA_W-1:0]       DEFAULT_DATA = 32'h0000000F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Mem_rd,
  input  logic                  Mem_wr,
  input  logic [ADDR_W-1:0]     Dir_Mem,
  input  logic [DATA_W-1:0]     Dato_Mem_in,
  input  logic [DATA_W/8-1:0]   Byte_en,
  output logic [DATA_W-1:0]     Dato_Mem_out,
  output logic                  Mem_busy,
  output logic                  Mem_ack,
  output logic                  Mem_err
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [NumBytes-1:0]   be_q;
  logic                  op_rd_q;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     dout_q, dout_d;
  logic                  accept;

  logic [DATA_W-1:0]     mem_q [DEPTH];

  // Address decode on the latched request address.
  logic [ADDR_W-1:0]     offset;
  logic                  in_lo, in_hi, aligned, addr_ok;
  logic [IdxW-1:0]       idx;
  logic                  access;
  logic                  mem_we;
  logic [DATA_W-1:0]     rdata;

  always_comb begin
    offset  = addr_q - BASE_ADDR;
    // An address below the base wraps the subtraction, so it is rejected explicitly.
    in_lo   = (addr_q >= BASE_ADDR);
    in_hi   = ((offset >> 2) < ADDR_W'(DEPTH));
    aligned = (addr_q[1:0] == 2'b00);
    addr_ok = in_lo & in_hi & aligned;
    idx     = offset[IdxW+1:2];
  end

  assign rdata  = mem_q[idx];
  assign access = (state_q == StWait) && (cnt_q == 4'd0);
  // rst has priority, so an access that coincides with reset never commits.
  assign mem_we = access & ~op_rd_q & addr_ok & ~rst;

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    dout_d  = dout_q;
    accept  = 1'b0;

    unique case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (!Mem_rd || !Mem_wr) begin
          accept  = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StDone;
          err_d   = ~addr_ok;
          if (op_rd_q) begin
            dout_d = addr_ok ? rdata : DEFAULT_DATA;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Request capture; the strobes are only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      op_rd_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= Dir_Mem;
      wdata_q <= Dato_Mem_in;
      be_q    <= Byte_en;
      op_rd_q <= ~Mem_rd;
    end
  end

`ifdef MEM_DATOS_INIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
      mem_q[0] <= DATA_W'(32'h0000000A);
      mem_q[1] <= DATA_W'(32'h0BE12120);
      mem_q[2] <= DATA_W'(32'h00000001);
    end else if (mem_we) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (be_q[i]) begin
          mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end
`else
  // No reset on the array so it can map to block or distributed RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (be_q[i]) begin
          mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end
`endif

  assign Dato_Mem_out = dout_q;
  assign Mem_busy     = (state_q == StWait);
  assign Mem_ack      = (state_q == StDone);
  assign Mem_err      = (state_q == StDone) & err_q;

endmodule

// File: tb/tb_mem_datos_param.sv
module tb_mem_datos_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;

  logic [31:0] dout, dout0, dout15;
  logic        busy, ack, err;
  logic        busy0, ack0, err0;
  logic        busy15, ack15, err15;

  int vectors = 0;
  int miscompares = 0;

  // Scratch used by the directed steps.
  int          lat, nbusy, nack;
  logic [31:0] q;
  logic        e;
  logic [2:0]  av;
  int          f_t [3];
  int          s_t [3];

  always #5 clk = ~clk;

  mem_datos_param u_dut (
    .clk          (clk),
    .rst          (rst),
    .Mem_rd       (rd_n),
    .Mem_wr       (wr_n),
    .Dir_Mem      (addr),
    .Dato_Mem_in  (wdata),
    .Byte_en      (be),
    .Dato_Mem_out (dout),
    .Mem_busy     (busy),
    .Mem_ack      (ack),
    .Mem_err      (err)
  );

  mem_datos_param #(.WAIT_STATES(0)) u_dut_w0 (
    .clk          (clk),
    .rst          (rst),
    .Mem_rd       (rd_n),
    .Mem_wr       (wr_n),
    .Dir_Mem      (addr),
    .Dato_Mem_in  (wdata),
    .Byte_en      (be),
    .Dato_Mem_out (dout0),
    .Mem_busy     (busy0),
    .Mem_ack      (ack0),
    .Mem_err      (err0)
  );

  mem_datos_param #(.WAIT_STATES(15)) u_dut_w15 (
    .clk          (clk),
    .rst          (rst),
    .Mem_rd       (rd_n),
    .Mem_wr       (wr_n),
    .Dir_Mem      (addr),
    .Dato_Mem_in  (wdata),
    .Byte_en      (be),
    .Dato_Mem_out (dout15),
    .Mem_busy     (busy15),
    .Mem_ack      (ack15),
    .Mem_err      (err15)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on the W=1 instance: strobe for one cycle, wait (bounded) for the ack,
  // capture data/error, then confirm the ack dropped after one cycle.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    rd_n = r; wr_n = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    rd_n = 1'b1; wr_n = 1'b1;
    lat = 0;
    nbusy = 0;
    while (ack !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    q = dout;
    e = err;
    @(negedge clk);
    chk("ack_one_cycle", {31'b0, ack}, 32'd0);
  endtask

  task automatic do_wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic exp_err);
    access(1'b1, 1'b0, a, d, b);
    chk({tag, "_lat"}, lat, 32'd2);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
  endtask

  task automatic do_rd(input string tag, input logic [31:0] a, input logic [31:0] exp_q,
                       input logic exp_err);
    access(1'b0, 1'b1, a, 32'h0, 4'h0);
    chk({tag, "_lat"}, lat, 32'd2);
    chk({tag, "_busy"}, nbusy, 32'd2);
    chk({tag, "_data"}, q, exp_q);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_dout", dout, 32'h0);

`ifdef MEM_DATOS_INIT_EN
    do_rd("init_w1", 32'h10000004, 32'h0BE12120, 1'b0);
`endif

    // Give the array known contents in either build.
    do_wr("ld_w0", 32'h10000000, 32'h0000000A, 4'hF, 1'b0);
    do_wr("ld_w1", 32'h10000004, 32'h0BE12120, 4'hF, 1'b0);
    do_wr("ld_w2", 32'h10000008, 32'h00000001, 4'hF, 1'b0);
    do_wr("ld_w15", 32'h1000003C, 32'h11111111, 4'hF, 1'b0);

    do_rd("rd_w1", 32'h10000004, 32'h0BE12120, 1'b0);

    // Partial-lane write.
    do_wr("wr_be3", 32'h10000008, 32'hDEADBEEF, 4'b0011, 1'b0);
    do_rd("rd_be3", 32'h10000008, 32'h0000BEEF, 1'b0);

    // No lanes enabled: acknowledged, nothing changes.
    do_wr("wr_be0", 32'h10000004, 32'hFFFFFFFF, 4'b0000, 1'b0);
    do_rd("rd_be0", 32'h10000004, 32'h0BE12120, 1'b0);

    // Error cases.
    do_rd("rd_oor", 32'h10000040, 32'h0000000F, 1'b1);
    do_rd("rd_top", 32'h1000003C, 32'h11111111, 1'b0);
    do_rd("rd_mis", 32'h10000002, 32'h0000000F, 1'b1);
    do_wr("wr_under", 32'h0FFFFFFC, 32'hFFFFFFFF, 4'hF, 1'b1);
    do_rd("chk_w15", 32'h1000003C, 32'h11111111, 1'b0);
    do_rd("chk_w0", 32'h10000000, 32'h0000000A, 1'b0);
    do_wr("wr_mis", 32'h10000005, 32'hFFFFFFFF, 4'hF, 1'b1);
    do_rd("chk_w1", 32'h10000004, 32'h0BE12120, 1'b0);

    // Both strobes low: treated as a read.
    access(1'b0, 1'b0, 32'h10000000, 32'h12345678, 4'hF);
    chk("both_data", q, 32'h0000000A);
    chk("both_err", {31'b0, e}, 32'd0);
    do_rd("both_after", 32'h10000000, 32'h0000000A, 1'b0);

    // Reset during WAIT aborts the write with no ack.
    @(negedge clk);
    wr_n = 1'b0; addr = 32'h10000000; wdata = 32'h00000055; be = 4'hF;
    @(negedge clk);
    wr_n = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nack = 0;
    repeat (6) begin
      if (ack === 1'b1) nack++;
      @(negedge clk);
    end
    chk("abort_no_ack", nack, 32'd0);
    chk("abort_dout", dout, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    do_rd("abort_w0", 32'h10000000, 32'h0000000A, 1'b0);

    // Latency sweep on W=0, 1, 15: single read pulse.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_n = 1'b0; addr = 32'h10000000;
    @(negedge clk);
    rd_n = 1'b1;
    for (int k = 0; k < 3; k++) f_t[k] = -1;
    for (int c = 0; c < 40; c++) begin
      av = {ack15, ack, ack0};
      for (int k = 0; k < 3; k++) if (av[k] === 1'b1 && f_t[k] < 0) f_t[k] = c;
      @(negedge clk);
    end
    chk("lat_w0", f_t[0], 32'd1);
    chk("lat_w1", f_t[1], 32'd2);
    chk("lat_w15", f_t[2], 32'd16);

    // Strobe held low: one ack every W+3 cycles.
    rd_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      f_t[k] = -1;
      s_t[k] = -1;
    end
    for (int c = 0; c < 60; c++) begin
      av = {ack15, ack, ack0};
      for (int k = 0; k < 3; k++) begin
        if (av[k] === 1'b1) begin
          if (f_t[k] < 0) f_t[k] = c;
          else if (s_t[k] < 0) s_t[k] = c;
        end
      end
      @(negedge clk);
    end
    rd_n = 1'b1;
    chk("period_w0", (s_t[0] < 0) ? -1 : s_t[0] - f_t[0], 32'd3);
    chk("period_w1", (s_t[1] < 0) ? -1 : s_t[1] - f_t[1], 32'd4);
    chk("period_w15", (s_t[2] < 0) ? -1 : s_t[2] - f_t[2], 32'd18);

    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/mem_datos_param.md
# mem_datos_param

Parametrised data memory for the single-cycle/multicycle processor datapath. It replaces the fixed three-register data store with a DEPTH-word, byte-writable array at a configurable base address. Accesses go through a request/acknowledge handshake with programmable wait states and report out-of-range and misaligned addresses. The block sits on the datapath's load/store path, driven by the control unit's active-low memory strobes.

## Interface
- DATA_W, 32, data word width; a multiple of 8.
- ADDR_W, 32, address width.
- DEPTH, 16, number of words; a power of two, at least 4.
- BASE_ADDR, 32'h10000000, byte address of word 0; word-aligned.
- WAIT_STATES, 1, extra cycles before the access completes; 0 to 15.
- DEFAULT_DATA, 32'h0000000F, value returned on an erroneous read.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Mem_rd  in  1  read request strobe, active-low.
- Mem_wr  in  1  write request strobe, active-low.
- Dir_Mem  in  ADDR_W  byte address.
- Dato_Mem_in  in  DATA_W  write data.
- Byte_en  in  DATA_W/8  write lane enables, active-high; lane i is bits [8i+7:8i].
- Dato_Mem_out  out  DATA_W  read data; holds its value until the next read completes.
- Mem_busy  out  1  high while a request is in progress (WAIT state).
- Mem_ack  out  1  one-cycle completion pulse.
- Mem_err  out  1  valid with Mem_ack; the completed access was out of range or misaligned.

## Operation
- States: IDLE, WAIT, DONE.
- **IDLE**
  - A request is accepted on an edge where Mem_rd==0 or Mem_wr==0.
  - If both are low, the request is a read; write has lower priority.
  - On accept, latch Dir_Mem, Dato_Mem_in, Byte_en and the operation type. Load the wait counter with WAIT_STATES. Go to WAIT.
- **WAIT**
  - If the counter is nonzero, decrement it.
  - If the counter is zero, perform the access, go to DONE.
  - Strobes and inputs are ignored in this state.
- **DONE**
  - Mem_ack=1 for exactly one cycle, then go to IDLE.
  - Strobes are ignored in this state.
- **Address decode**
  - The access is valid when Dir_Mem >= BASE_ADDR, (Dir_Mem-BASE_ADDR)>>2 < DEPTH, and Dir_Mem[1:0]==0.
  - Word index = (Dir_Mem-BASE_ADDR)>>2. The subtraction is computed at ADDR_W width; an underflow counts as out of range.
- **Read**
  - Valid: Dato_Mem_out <= word.
  - Invalid: Dato_Mem_out <= DEFAULT_DATA and Mem_err=1.
- **Write**
  - Valid: only lanes with Byte_en[i]==1 are updated. Byte_en all zero still acknowledges, with no change and Mem_err=0.
  - Invalid: the write is discarded and Mem_err=1.
- Mem_err is 0 whenever Mem_ack is 0.
- **Reset**
  - Reset goes to IDLE and clears the counter.
  - Mem_busy=0, Mem_ack=0, Mem_err=0, Dato_Mem_out=0.
  - Asserting rst mid-request aborts the request. No write is performed and no ack is issued.
  - Memory contents on reset: see Configuration.

## Timing
- Request sampled at edge t:
  - Mem_busy=1 from t to t+W+1, where W = WAIT_STATES.
  - Access happens at edge t+W+1.
  - Mem_ack, Mem_err and the new Dato_Mem_out are valid in the cycle after edge t+W+1.
- Back in IDLE after edge t+W+2. The earliest next accept is edge t+W+3, so the minimum request period is W+3 cycles.
- A strobe held low through DONE and into IDLE is accepted again as a new request. The control unit must deassert the strobe on Mem_ack.
- Write data is visible to a read accepted on any later cycle.

## Configuration
- MEM_DATOS_INIT_EN defined:
  - rst loads word0=32'h0000000A, word1=32'h0BE12120, word2=32'h00000001; all other words are 0.
  - The array is built from reset flops.
- MEM_DATOS_INIT_EN undefined:
  - rst does not touch the array; contents are undefined until written.
  - The array must infer as block/distributed RAM.
  - Control state and outputs still reset as above.

## Test plan
All scenarios use default parameters (W=1) with MEM_DATOS_INIT_EN defined unless stated.

- Reset, then read at 0x10000004: Mem_busy=1 for 2 cycles. Mem_ack in cycle 3 after accept with Dato_Mem_out=0x0BE12120 and Mem_err=0.
- Write 0x10000008 with data 0xDEADBEEF and Byte_en=4'b0011, then read 0x10000008: read returns 0x0000BEEF.
- Read 0x10000040 (index 16): Mem_err=1 and Dato_Mem_out=0x0000000F. Read 0x10000002 (misaligned): Mem_err=1. Write to 0x0FFFFFFC: Mem_err=1 and all words unchanged.
- Mem_rd=0 and Mem_wr=0 together at 0x10000000 with data 0x12345678: behaves as a read returning 0x0000000A; a following read still returns 0x0000000A.
- Write 0x10000000 with 0x55 and rst pulsed during WAIT: no Mem_ack. After reset, a read returns 0x0000000A. Without MEM_DATOS_INIT_EN, the read returns the pre-reset contents.
- WAIT_STATES=0 and WAIT_STATES=15 sweep: ack arrives exactly W+1 cycles after accept. Strobes held low continuously give one ack every W+3 cycles.
